stream_onehot_mux: RTL and testbench
====================================

// Module: stream_onehot_mux
// PURPOSE
//   N-channel valid/ready stream multiplexer steered by a one-hot select; successor to the
//   combinational one-hot mux. Adds per-channel handshakes, a registered skid-buffered output
//   (no comb path out_ready->in_ready), optional packet locking on *_last, and select-error flagging.
//   Sits between N producer streams and one consumer (e.g. shared DMA or serializer port).
// PARAMETERS
//   DW        8  data width per channel, >=1
//   N         4  channel count, >=2
//   LOCK_PKT  1  1: hold channel until beat with last=1 accepted; 0: re-evaluate sel every beat
// PORTS
//   clk        in   1     clock, all logic on rising edge
//   rst        in   1     synchronous, active-high reset
//   sel        in   N     one-hot channel select; all-zero = no channel
//   in_valid   in   N     per-channel valid
//   in_data    in   N*DW  channel i at in_data[(i+1)*DW-1 -: DW]
//   in_last    in   N     per-channel end-of-packet
//   in_ready   out  N     per-channel ready; at most one bit high
//   out_valid  out  1     output valid (registered)
//   out_data   out  DW    output data (registered)
//   out_last   out  1     output end-of-packet (registered)
//   out_ready  in   1     downstream ready
//   sel_err    out  1     registered 1-cycle pulse: illegal sel while IDLE
// BEHAVIOUR
//   Reset: out_valid=0, out_data=0, out_last=0, sel_err=0, FSM=IDLE, skid empty, sel_q=0.
//     in_ready forced 0 while rst=1. Reset mid-packet discards lock and buffered beats.
//   Active select: act_sel = (FSM==LOCKED) ? sel_q : sel.
//   sel legal iff $onehot(sel). In IDLE with sel!=0 and not one-hot: all in_ready=0, sel_err=1
//     next cycle. sel==0: in_ready=0, no error. In LOCKED, sel ignored, never flags error.
//   in_ready[i] = act_sel[i] & legal_or_locked & ~skid_full; ready never depends on in_valid.
//   Accept on channel i: in_valid[i] & in_ready[i]. Valids of unselected channels ignored.
//   FSM (LOCK_PKT=1):
//     IDLE  -> LOCKED on accept with in_last=0; sel_q <= sel.
//     IDLE  stays on accept with in_last=1 (single-beat packet) or no accept.
//     LOCKED-> IDLE on accept with in_last=1; LOCKED holds with no accept (bubbles allowed).
//   LOCK_PKT=0: FSM held in IDLE; channel may change every beat; in_last passed through only.
//   Output stage: main reg + 1-entry skid reg.
//     Accept with main empty or (out_valid & out_ready): beat -> main; out_valid=1 next cycle.
//     Accept while main holds a stalled beat: beat -> skid; skid_full=1, in_ready drops next cycle.
//     out_valid & out_ready with skid full: skid -> main, skid empties.
//     out_data/out_last stable while out_valid & ~out_ready (AXI-stream rule).
//   Latency 1 cycle accept->out_valid; throughput 1 beat/cycle with out_ready=1.
//   Beat order preserved; no beat dropped or duplicated.
// TESTING
//   1 Reset: hold rst 3 cycles with in_valid=all 1, sel=4'b0001 -> in_ready=0, out_valid=0, sel_err=0.
//   2 Streaming: sel=4'b0100, ch2 sends 0x11,0x22,0x33 (last on 0x33), out_ready=1 ->
//     out_data 0x11,0x22,0x33 on consecutive cycles, each 1 cycle after accept; out_last on 0x33.
//   3 Lock: LOCK_PKT=1, ch0 packet 4 beats; switch sel to 4'b0010 after beat 1 -> remaining
//     ch0 beats delivered, in_ready[1]=0 until ch0 last accepted, then ch1 served.
//   4 Backpressure: out_ready=0 while streaming ch3 -> exactly 2 beats accepted (main+skid),
//     in_ready[3]=0 thereafter; release out_ready -> all beats in order, none lost.
//   5 Illegal sel: IDLE, sel=4'b0110 -> all in_ready=0, sel_err=1 for 1 cycle after each
//     illegal cycle; sel=4'b0000 -> no sel_err; in LOCKED, sel=4'b1111 -> no error, lock held.
//   6 LOCK_PKT=0: alternate sel 4'b0001/4'b1000 each cycle, both valid -> output alternates
//     ch0/ch3 data each cycle, FSM never LOCKED.

Source files
------------

// File: rtl/stream_onehot_mux.sv
// N-channel valid/ready stream mux steered by a one-hot select, with optional packet locking,
// select-error flagging and a registered main+skid output stage.
module stream_onehot_mux #(
  parameter int unsigned DW       = 8,
  parameter int unsigned N        = 4,
  parameter int unsigned LOCK_PKT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    sel,
  input  logic [N-1:0]    in_valid,
  input  logic [N*DW-1:0] in_data,
  input  logic [N-1:0]    in_last,
  output logic [N-1:0]    in_ready,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic            out_last,
  input  logic            out_ready,
  output logic            sel_err
);

  typedef enum logic {StIdle, StLocked} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   sel_q, sel_d;
  logic [N-1:0]   act_sel;
  logic           sel_legal;
  logic           sel_ok;
  logic           sel_err_d;

  logic           main_valid_q;
  logic [DW-1:0]  main_data_q;
  logic           main_last_q;
  logic           skid_full_q;
  logic [DW-1:0]  skid_data_q;
  logic           skid_last_q;

  logic           accept;
  logic [DW-1:0]  beat_data;
  logic           beat_last;
  logic           pop;

  assign sel_legal = $onehot(sel);
  assign act_sel   = (state_q == StLocked) ? sel_q : sel;
  assign sel_ok    = (state_q == StLocked) || sel_legal;
  assign sel_err_d = (state_q == StIdle) && (|sel) && !sel_legal;
  assign pop       = main_valid_q && out_ready;

  // Ready is a function of registered state and sel only, never of in_valid or out_ready.
  always_comb begin
    in_ready = '0;
    if (!rst && sel_ok && !skid_full_q) begin
      in_ready = act_sel;
    end
  end

  // in_ready has at most one bit set, so a priority scan acts as a one-hot mux.
  always_comb begin
    accept    = 1'b0;
    beat_data = '0;
    beat_last = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (in_ready[i] && in_valid[i]) begin
        accept    = 1'b1;
        beat_data = in_data[i*DW +: DW];
        beat_last = in_last[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    if (LOCK_PKT != 0 && accept) begin
      unique case (state_q)
        StIdle: begin
          if (!beat_last) begin
            state_d = StLocked;
            sel_d   = sel;
          end
        end
        StLocked: begin
          if (beat_last) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sel_q   <= '0;
      sel_err <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      sel_err <= sel_err_d;
    end
  end

  // Skid only fills while main is stalled; it drains into main on the next pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_last_q  <= 1'b0;
      skid_full_q  <= 1'b0;
      skid_data_q  <= '0;
      skid_last_q  <= 1'b0;
    end else if (pop) begin
      if (skid_full_q) begin
        main_data_q <= skid_data_q;
        main_last_q <= skid_last_q;
        skid_full_q <= 1'b0;
      end else if (accept) begin
        main_data_q <= beat_data;
        main_last_q <= beat_last;
      end else begin
        main_valid_q <= 1'b0;
      end
    end else if (accept) begin
      if (!main_valid_q) begin
        main_valid_q <= 1'b1;
        main_data_q  <= beat_data;
        main_last_q  <= beat_last;
      end else begin
        skid_full_q <= 1'b1;
        skid_data_q <= beat_data;
        skid_last_q <= beat_last;
      end
    end
  end

  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign out_last  = main_last_q;

endmodule

// File: tb/tb_stream_onehot_mux.sv
// Bench for stream_onehot_mux: a locking and a non-locking instance share stimulus and are
// checked each cycle against a queue-level reference model.
module tb_stream_onehot_mux;

  localparam int DW = 8;
  localparam int N  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  sel;
  logic [N-1:0]  in_valid;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]  in_last;
  logic          out_ready;

  logic [N-1:0]  ir_l, ir_f;
  logic          ov_l, ov_f, ol_l, ol_f, se_l, se_f;
  logic [DW-1:0] od_l, od_f;

  int total  = 0;
  int passed = 0;

  // Model state per instance (0: LOCK_PKT=1, 1: LOCK_PKT=0): a 2-deep FIFO of pending beats.
  logic [DW-1:0] mdata [2][2];
  logic          mlast [2][2];
  int            mcnt  [2];
  bit            mlocked [2];
  logic [N-1:0]  msel  [2];
  logic          merr  [2];
  bit            macc  [2];

  always #5 clk = ~clk;

  stream_onehot_mux #(.DW(DW), .N(N), .LOCK_PKT(1)) u_lock (
    .clk(clk), .rst(rst), .sel(sel), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(ir_l), .out_valid(ov_l), .out_data(od_l),
    .out_last(ol_l), .out_ready(out_ready), .sel_err(se_l)
  );

  stream_onehot_mux #(.DW(DW), .N(N), .LOCK_PKT(0)) u_free (
    .clk(clk), .rst(rst), .sel(sel), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(ir_f), .out_valid(ov_f), .out_data(od_f),
    .out_last(ol_f), .out_ready(out_ready), .sel_err(se_f)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [N-1:0] exp_ready(input int k);
    logic [N-1:0] act;
    bit ok;
    if (rst) return '0;
    act = mlocked[k] ? msel[k] : sel;
    ok  = mlocked[k] || ($countones(sel) == 1);
    return (ok && mcnt[k] < 2) ? act : '0;
  endfunction

  task automatic tick();
    logic [N-1:0]  ir, r;
    logic          ov, ol, se;
    logic [DW-1:0] od;
    int            ch;
    bit            err;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      ir = (k == 0) ? ir_l : ir_f;
      ov = (k == 0) ? ov_l : ov_f;
      od = (k == 0) ? od_l : od_f;
      ol = (k == 0) ? ol_l : ol_f;
      se = (k == 0) ? se_l : se_f;
      r  = exp_ready(k);
      check($sformatf("in_ready[%0d]", k), 32'(ir), 32'(r));
      check($sformatf("out_valid[%0d]", k), 32'(ov), 32'(mcnt[k] > 0));
      check($sformatf("sel_err[%0d]", k), 32'(se), 32'(merr[k]));
      if (mcnt[k] > 0) begin
        check($sformatf("out_data[%0d]", k), 32'(od), 32'(mdata[k][0]));
        check($sformatf("out_last[%0d]", k), 32'(ol), 32'(mlast[k][0]));
      end
      // Advance the model across the coming rising edge.
      macc[k] = 1'b0;
      if (rst) begin
        mcnt[k] = 0; mlocked[k] = 1'b0; msel[k] = '0; merr[k] = 1'b0;
      end else begin
        err = !mlocked[k] && (sel != 0) && ($countones(sel) != 1);
        ch  = -1;
        for (int i = 0; i < N; i++) if (r[i] && in_valid[i]) ch = i;
        if (mcnt[k] > 0 && out_ready) begin
          mdata[k][0] = mdata[k][1];
          mlast[k][0] = mlast[k][1];
          mcnt[k]--;
        end
        if (ch >= 0) begin
          macc[k] = 1'b1;
          mdata[k][mcnt[k]] = in_data[ch*DW +: DW];
          mlast[k][mcnt[k]] = in_last[ch];
          mcnt[k]++;
          if (k == 0) begin
            if (!mlocked[k] && !in_last[ch]) begin
              mlocked[k] = 1'b1;
              msel[k]    = sel;
            end else if (mlocked[k] && in_last[ch]) begin
              mlocked[k] = 1'b0;
            end
          end
        end
        merr[k] = err;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [DW-1:0] d, input logic l);
    in_data[ch*DW +: DW] = d;
    in_last[ch]          = l;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    for (int i = 0; i < cycles; i++) tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] d;
    for (int k = 0; k < 2; k++) begin
      mcnt[k] = 0; mlocked[k] = 1'b0; msel[k] = '0; merr[k] = 1'b0; macc[k] = 1'b0;
      for (int j = 0; j < 2; j++) begin mdata[k][j] = '0; mlast[k][j] = 1'b0; end
    end
    rst = 1'b1; sel = 4'b0001; in_valid = 4'b1111; in_data = '0; in_last = '0; out_ready = 1'b1;
    #1;

    // Reset with everything asserted.
    do_reset(3);
    check("reset out_data", 32'(od_l), 32'h0);
    check("reset out_last", 32'(ol_l), 32'h0);

    // Streaming on channel 2.
    sel = 4'b0100; in_valid = 4'b0100;
    set_ch(2, 8'h11, 1'b0); tick();
    set_ch(2, 8'h22, 1'b0); tick();
    set_ch(2, 8'h33, 1'b1); tick();
    in_valid = '0; tick(); tick();

    // Lock: channel 0 packet of 4 beats, sel moves to ch1 after beat 1.
    sel = 4'b0001; in_valid = 4'b0011;
    set_ch(1, 8'hB0, 1'b1);
    for (int b = 0; b < 4; b++) begin
      set_ch(0, 8'hA0 + 8'(b), b == 3);
      tick();
      sel = 4'b0010;
    end
    tick(); tick();
    in_valid = '0; tick();

    // Backpressure on channel 3.
    sel = 4'b1000; in_valid = 4'b1000; out_ready = 1'b0; d = 8'h40;
    set_ch(3, d, 1'b1);
    for (int c = 0; c < 5; c++) begin
      tick();
      if (macc[0]) begin d++; set_ch(3, d, 1'b1); end
    end
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (macc[0]) begin d++; set_ch(3, d, 1'b1); end
    end
    in_valid = '0; tick(); tick();

    // Illegal and empty selects, then lock held under sel=1111.
    sel = 4'b0110; in_valid = 4'b1111; tick(); tick();
    sel = 4'b0000; tick(); tick();
    sel = 4'b0001; in_valid = 4'b0001; set_ch(0, 8'h5A, 1'b0); tick();
    sel = 4'b1111; in_valid = 4'b1111;
    for (int c = 0; c < 3; c++) begin set_ch(0, 8'h5B + 8'(c), 1'b0); tick(); end
    set_ch(0, 8'h5F, 1'b1); tick();
    sel = 4'b0000; in_valid = '0; tick(); tick();

    // Alternating select, both channels valid.
    do_reset(1);
    in_valid = 4'b1001; in_last = '0;
    for (int c = 0; c < 8; c++) begin
      sel = c[0] ? 4'b1000 : 4'b0001;
      set_ch(0, 8'h00 + 8'(c), 1'b0);
      set_ch(3, 8'hF0 + 8'(c), 1'b0);
      tick();
    end
    in_valid = '0; tick(); tick();

    // Randomised traffic.
    do_reset(1);
    for (int c = 0; c < 400; c++) begin
      case ($urandom_range(0, 5))
        0:       sel = 4'($urandom);
        1:       sel = '0;
        default: sel = 4'(1 << $urandom_range(0, 3));
      endcase
      in_valid  = 4'($urandom);
      in_data   = $urandom;
      in_last   = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
